// File: rtl/lcd_reg_reader_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the LCD register reader.
//   lcd_rd_state_t : sequencer state encoding
//   LCD_CMD_*      : common panel read commands (ID / status)
//   cyc_max        : elaboration-time helper used to size the step counter
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    SETUP,
    WR_LO,
    WR_HI,
    TURN,
    RD_LO,
    RD_HI,
    DONE
  } lcd_rd_state_t;

  localparam logic [7:0] LCD_CMD_RDDID = 8'h04;
  localparam logic [7:0] LCD_CMD_RDDST = 8'h09;
  localparam logic [7:0] LCD_CMD_RDID4 = 8'hD3;

  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_reg_reader_if.sv
// -----------------------------------------------------------------------------
// lcd_reg_reader_if
// Bundles the requester handshake, the bus arbitration pair and the 8080-style
// LCD pins used by the register reader.
//   master : the reader itself (drives strobes, bus request, results)
//   slave  : requester / display writer / panel side
// -----------------------------------------------------------------------------
interface lcd_reg_reader_if #(
  parameter int MAX_BYTES = 4
);
  localparam int NBW = $clog2(MAX_BYTES + 1);

  logic                   req;
  logic [7:0]             cmd;
  logic [NBW-1:0]         nbytes;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [8*MAX_BYTES-1:0] rdata;
  logic                   bus_req;
  logic                   bus_gnt;
  logic [7:0]             lcd_db_out;
  logic                   lcd_db_oe;
  logic [7:0]             lcd_db_in;
  logic                   lcd_wr;
  logic                   lcd_rd;
  logic                   lcd_d_c;

  modport master (
    input  req, cmd, nbytes, bus_gnt, lcd_db_in,
    output busy, done, err, rdata, bus_req,
           lcd_db_out, lcd_db_oe, lcd_wr, lcd_rd, lcd_d_c
  );

  modport slave (
    output req, cmd, nbytes, bus_gnt, lcd_db_in,
    input  busy, done, err, rdata, bus_req,
           lcd_db_out, lcd_db_oe, lcd_wr, lcd_rd, lcd_d_c
  );

endinterface

// File: rtl/lcd_reg_reader_strobe_timer.sv
// -----------------------------------------------------------------------------
// lcd_strobe_timer
// Loadable down-counter shared by every phase of the reader.
//   clk, resetN  : clock, async active-low reset
//   load_i       : reload the counter this cycle
//   load_val_i   : phase length minus one
//   expire_o     : high while the count is zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module lcd_strobe_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Loading N-1 on state entry makes expire_o rise in the Nth cycle of the
  // phase, so the sequencer leaves exactly N cycles after it entered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_reg_reader.sv
// -----------------------------------------------------------------------------
// lcd_reg_reader
// Read-side master for the 8080 parallel LCD bus. Borrows the bus from the
// display writer, writes one command byte, performs one dummy read plus N
// data reads and returns the bytes (first real byte in rdata[7:0]).
//   clk, resetN : 25 MHz clock, async active-low reset
//   bus         : requester handshake (req/cmd/nbytes/busy/done/err/rdata),
//                 arbitration (bus_req/bus_gnt) and LCD pins
// All outputs are registered and decoded from the next state.
// -----------------------------------------------------------------------------
module lcd_reg_reader
  import lcd_pkg::*;
#(
  parameter int MAX_BYTES   = 4,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 10,
  parameter int RD_HIGH_CYC = 4
) (
  input  logic             clk,
  input  logic             resetN,
  lcd_reg_reader_if.master bus
);

  localparam int NBW     = $clog2(MAX_BYTES + 1);
  localparam int BCW     = $clog2(MAX_BYTES + 2);
  localparam int MAX_CYC = cyc_max(cyc_max(WR_LOW_CYC, WR_HIGH_CYC),
                                   cyc_max(RD_LOW_CYC, RD_HIGH_CYC));
  localparam int STEP_W  = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

  lcd_rd_state_t          state_q, state_d;
  logic [7:0]             cmd_q;
  logic [NBW-1:0]         nb_q;
  logic [NBW-1:0]         nb_clamped;
  logic [BCW-1:0]         byte_cnt_q;
  logic [8*MAX_BYTES-1:0] rdata_q;
  logic                   busy_q, done_q, err_q, bus_req_q;
  logic [7:0]             db_out_q;
  logic                   db_oe_q, wr_q, rd_q, d_c_q;
  logic                   abort;
  logic                   drive_cmd;
  logic                   tmr_load, tmr_exp;
  logic [STEP_W-1:0]      tmr_val;

  assign nb_clamped = (bus.nbytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : bus.nbytes;

  lcd_strobe_timer #(.W(STEP_W)) u_timer (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_exp)
  );

  // Next-state logic. Once the bus is owned, losing the grant in any phase
  // abandons the transaction and reports it through err on the done pulse.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (bus.req) state_d = ARB;
      ARB:  if (bus.bus_gnt) state_d = SETUP;
      SETUP, WR_LO, WR_HI, TURN, RD_LO, RD_HI: begin
        if (!bus.bus_gnt) begin
          abort   = 1'b1;
          state_d = DONE;
        end else if (tmr_exp) begin
          case (state_q)
            SETUP:   state_d = WR_LO;
            WR_LO:   state_d = WR_HI;
            WR_HI:   state_d = (nb_q == '0) ? DONE : TURN;
            TURN:    state_d = RD_LO;
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = (byte_cnt_q == BCW'(nb_q)) ? DONE : RD_LO;
            default: state_d = state_q;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The step counter reloads on every state change with the length of the
  // phase being entered; single-cycle phases load zero and expire at once.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      WR_LO:   tmr_val = STEP_W'(WR_LOW_CYC - 1);
      WR_HI:   tmr_val = STEP_W'(WR_HIGH_CYC - 1);
      RD_LO:   tmr_val = STEP_W'(RD_LOW_CYC - 1);
      RD_HI:   tmr_val = STEP_W'(RD_HIGH_CYC - 1);
      default: tmr_val = '0;
    endcase
  end

  assign drive_cmd = (state_d == SETUP) || (state_d == WR_LO) || (state_d == WR_HI);

  // Sequencer registers and registered outputs. Outputs follow state_d so each
  // pin level lines up with the state occupying that cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      nb_q       <= '0;
      byte_cnt_q <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bus_req_q  <= 1'b0;
      db_out_q   <= '0;
      db_oe_q    <= 1'b0;
      wr_q       <= 1'b1;
      rd_q       <= 1'b1;
      d_c_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      bus_req_q <= (state_d != IDLE) && (state_d != DONE);
      wr_q      <= (state_d != WR_LO);
      rd_q      <= (state_d != RD_LO);
      db_oe_q   <= drive_cmd;
      d_c_q     <= !drive_cmd;
      db_out_q  <= drive_cmd ? cmd_q : 8'h00;

      if (state_q == IDLE && bus.req) begin
        cmd_q   <= bus.cmd;
        nb_q    <= nb_clamped;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end

      if (abort) begin
        err_q <= 1'b1;
      end

      // Iteration 0 is the panel's dummy read; iteration k lands in byte k-1.
      if (state_d == TURN) begin
        byte_cnt_q <= '0;
      end else if (state_q == RD_HI && state_d == RD_LO) begin
        byte_cnt_q <= byte_cnt_q + BCW'(1);
      end

      // Capture on the edge that raises lcd_rd; a grant loss on that same edge
      // skips the capture because the next state is DONE, not RD_HI.
      if (state_q == RD_LO && state_d == RD_HI) begin
        for (int k = 0; k < MAX_BYTES; k++) begin
          if (byte_cnt_q == BCW'(k + 1)) begin
            rdata_q[8*k +: 8] <= bus.lcd_db_in;
          end
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.bus_req    = bus_req_q;
  assign bus.lcd_db_out = db_out_q;
  assign bus.lcd_db_oe  = db_oe_q;
  assign bus.lcd_wr     = wr_q;
  assign bus.lcd_rd     = rd_q;
  assign bus.lcd_d_c    = d_c_q;

endmodule
